mem_access_ctrl: RTL and testbench

- Memory-access sequencer directly downstream of the MEM/WB pipeline register.
- Consumes the register's held address, store data, control word and `ready`/`second_cycle_request` handshake.
- Drives the data-cache port and returns the one-cycle `data_response` pulse the register waits on.
- Handles word, byte and indirect (LDI/STI, two-access) transfers, and formats load data for write-back.

---
 rtl/mem_access_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_mem_access_ctrl.sv | 508 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_ctrl.sv
// Data-memory access sequencer behind the MEM/WB register.
// Drives word, byte and indirect cache accesses and formats load data.
module mem_access_ctrl #(
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 ready,
    input  logic                 second_cycle_request,
    input  logic [3:0]           opcode,
    input  logic                 mem_read,
    input  logic                 mem_write,
    input  logic [15:0]          addr_in,
    input  logic [15:0]          wdata_in,
    input  logic                 dmem_resp,
    input  logic [15:0]          dmem_rdata,
    output logic                 dmem_read,
    output logic                 dmem_write,
    output logic [15:0]          dmem_address,
    output logic [15:0]          dmem_wdata,
    output logic [1:0]           dmem_byte_enable,
    output logic                 data_response,
    output logic [15:0]          mem_rdata_out,
    output logic                 busy,
    output logic [CNT_WIDTH-1:0] stall_cycles
);

    localparam logic [3:0] OP_LDB = 4'b0010;
    localparam logic [3:0] OP_STB = 4'b0011;
    localparam logic [3:0] OP_LDI = 4'b1010;
    localparam logic [3:0] OP_STI = 4'b1011;

    typedef enum logic [2:0] {IDLE, ACC1, WAIT2, ACC2, DONE} state_t;

    state_t state, state_n;

    logic [3:0]  op_q, op_n;
    logic        lane_q, lane_n;
    logic        rd_q, rd_n;
    logic [15:0] wdata_q, wdata_n;
    logic [15:0] ptr_q, ptr_n;

    logic        read_n, write_n, resp_n, busy_n;
    logic [15:0] address_n, dwdata_n, rdata_n;
    logic [1:0]  be_n;
    logic [CNT_WIDTH-1:0] stall_n;

    logic       start, ind_in, byte_in, ind_q, byte_q;
    logic [7:0] lane_byte;

    assign start   = !ready && (mem_read || mem_write) && !second_cycle_request;
    assign ind_in  = (opcode == OP_LDI) || (opcode == OP_STI);
    assign byte_in = (opcode == OP_LDB) || (opcode == OP_STB);
    assign ind_q   = (op_q == OP_LDI) || (op_q == OP_STI);
    assign byte_q  = (op_q == OP_LDB) || (op_q == OP_STB);
    assign lane_byte = lane_q ? dmem_rdata[15:8] : dmem_rdata[7:0];

    always_comb begin
        state_n   = state;
        op_n      = op_q;
        lane_n    = lane_q;
        rd_n      = rd_q;
        wdata_n   = wdata_q;
        ptr_n     = ptr_q;
        read_n    = dmem_read;
        write_n   = dmem_write;
        address_n = dmem_address;
        dwdata_n  = dmem_wdata;
        be_n      = dmem_byte_enable;
        resp_n    = 1'b0;
        rdata_n   = mem_rdata_out;

        unique case (state)
            IDLE: begin
                if (start) begin
                    state_n = ACC1;
                    op_n    = opcode;
                    lane_n  = addr_in[0];
                    rd_n    = mem_read;
                    wdata_n = wdata_in;
                    if (ind_in) begin
                        // first leg of LDI/STI always fetches the pointer
                        read_n    = 1'b1;
                        write_n   = 1'b0;
                        address_n = {addr_in[15:1], 1'b0};
                        be_n      = 2'b11;
                        dwdata_n  = wdata_in;
                    end else if (byte_in) begin
                        read_n    = mem_read;
                        write_n   = mem_write && !mem_read;
                        address_n = addr_in;
                        be_n      = addr_in[0] ? 2'b10 : 2'b01;
                        dwdata_n  = {wdata_in[7:0], wdata_in[7:0]};
                    end else begin
                        read_n    = mem_read;
                        write_n   = mem_write && !mem_read;
                        address_n = {addr_in[15:1], 1'b0};
                        be_n      = 2'b11;
                        dwdata_n  = wdata_in;
                    end
                end
            end
            ACC1: begin
                if (dmem_resp) begin
                    read_n  = 1'b0;
                    write_n = 1'b0;
                    resp_n  = 1'b1;
                    if (ind_q) begin
                        ptr_n   = dmem_rdata;
                        state_n = WAIT2;
                    end else begin
                        if (rd_q) begin
                            rdata_n = byte_q ? {{8{lane_byte[7]}}, lane_byte}
                                             : dmem_rdata;
                        end
                        state_n = DONE;
                    end
                end
            end
            WAIT2: begin
                if (ready) begin
                    state_n = IDLE;
                end else if (second_cycle_request) begin
                    state_n   = ACC2;
                    read_n    = (op_q == OP_LDI);
                    write_n   = (op_q == OP_STI);
                    address_n = ptr_q & 16'hFFFE;
                    be_n      = 2'b11;
                    dwdata_n  = wdata_q;
                end
            end
            ACC2: begin
                if (dmem_resp) begin
                    read_n  = 1'b0;
                    write_n = 1'b0;
                    resp_n  = 1'b1;
                    if (op_q == OP_LDI) begin
                        rdata_n = dmem_rdata;
                    end
                    state_n = DONE;
                end
            end
            DONE: begin
                // hold until MEM/WB drops its request so stale ready=0 can't retrigger
                if (ready) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase

        busy_n  = (state_n != IDLE);
        stall_n = stall_cycles + {{(CNT_WIDTH-1){1'b0}}, busy};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= IDLE;
            op_q             <= 4'h0;
            lane_q           <= 1'b0;
            rd_q             <= 1'b0;
            wdata_q          <= 16'h0;
            ptr_q            <= 16'h0;
            dmem_read        <= 1'b0;
            dmem_write       <= 1'b0;
            dmem_address     <= 16'h0;
            dmem_wdata       <= 16'h0;
            dmem_byte_enable <= 2'b00;
            data_response    <= 1'b0;
            mem_rdata_out    <= 16'h0;
            busy             <= 1'b0;
            stall_cycles     <= '0;
        end else begin
            state            <= state_n;
            op_q             <= op_n;
            lane_q           <= lane_n;
            rd_q             <= rd_n;
            wdata_q          <= wdata_n;
            ptr_q            <= ptr_n;
            dmem_read        <= read_n;
            dmem_write       <= write_n;
            dmem_address     <= address_n;
            dmem_wdata       <= dwdata_n;
            dmem_byte_enable <= be_n;
            data_response    <= resp_n;
            mem_rdata_out    <= rdata_n;
            busy             <= busy_n;
            stall_cycles     <= stall_n;
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with a hand-driven cache.
// Counter is built 4 bits wide so wraparound is reachable.
module tb_mem_access_ctrl;

    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_LDB = 4'b0010;
    localparam logic [3:0] OP_STB = 4'b0011;
    localparam logic [3:0] OP_LDW = 4'b0110;
    localparam logic [3:0] OP_LDI = 4'b1010;
    localparam logic [3:0] OP_STI = 4'b1011;

    logic        clk = 1'b0;
    logic        reset;
    logic        ready;
    logic        second_cycle_request;
    logic [3:0]  opcode;
    logic        mem_read;
    logic        mem_write;
    logic [15:0] addr_in;
    logic [15:0] wdata_in;
    logic        dmem_resp;
    logic [15:0] dmem_rdata;
    logic        dmem_read;
    logic        dmem_write;
    logic [15:0] dmem_address;
    logic [15:0] dmem_wdata;
    logic [1:0]  dmem_byte_enable;
    logic        data_response;
    logic [15:0] mem_rdata_out;
    logic        busy;
    logic [3:0]  stall_cycles;

    int checks = 0;
    int errors = 0;
    int pulses = 0;

    mem_access_ctrl #(.CNT_WIDTH(4)) dut (
        .clk                  (clk),
        .reset                (reset),
        .ready                (ready),
        .second_cycle_request (second_cycle_request),
        .opcode               (opcode),
        .mem_read             (mem_read),
        .mem_write            (mem_write),
        .addr_in              (addr_in),
        .wdata_in             (wdata_in),
        .dmem_resp            (dmem_resp),
        .dmem_rdata           (dmem_rdata),
        .dmem_read            (dmem_read),
        .dmem_write           (dmem_write),
        .dmem_address         (dmem_address),
        .dmem_wdata           (dmem_wdata),
        .dmem_byte_enable     (dmem_byte_enable),
        .data_response        (data_response),
        .mem_rdata_out        (mem_rdata_out),
        .busy                 (busy),
        .stall_cycles         (stall_cycles)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
        if (data_response === 1'b1) pulses++;
    endtask

    task automatic idle_inputs;
        ready = 1'b1;
        second_cycle_request = 1'b0;
        opcode = 4'h0;
        mem_read = 1'b0;
        mem_write = 1'b0;
        addr_in = 16'h0;
        wdata_in = 16'h0;
        dmem_resp = 1'b0;
        dmem_rdata = 16'h0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        idle_inputs();
        tick();
        tick();
        checks++;
        if ({dmem_read, dmem_write, dmem_byte_enable} !== 4'b0) begin
            errors++;
            $display("FAIL rst_strobes: got %b expected 0000",
                     {dmem_read, dmem_write, dmem_byte_enable});
        end
        checks++;
        if ({dmem_address, dmem_wdata} !== 32'h0) begin
            errors++;
            $display("FAIL rst_addr_wdata: got %h expected 0",
                     {dmem_address, dmem_wdata});
        end
        checks++;
        if ({data_response, busy, mem_rdata_out, stall_cycles} !== 22'h0) begin
            errors++;
            $display("FAIL rst_status: got %h expected 0",
                     {data_response, busy, mem_rdata_out, stall_cycles});
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_ldw;
        pulses = 0;
        opcode = OP_LDW;
        addr_in = 16'h3001;
        mem_read = 1'b1;
        ready = 1'b0;
        tick();
        checks++;
        if ({dmem_read, dmem_write, busy} !== 3'b101) begin
            errors++;
            $display("FAIL ldw_strobe: got %b expected 101",
                     {dmem_read, dmem_write, busy});
        end
        checks++;
        if (dmem_address !== 16'h3000 || dmem_byte_enable !== 2'b11) begin
            errors++;
            $display("FAIL ldw_addr_be: got %h/%b expected 3000/11",
                     dmem_address, dmem_byte_enable);
        end
        tick();
        tick();
        checks++;
        if (dmem_read !== 1'b1 || dmem_address !== 16'h3000) begin
            errors++;
            $display("FAIL ldw_hold: got %b/%h expected 1/3000",
                     dmem_read, dmem_address);
        end
        dmem_resp = 1'b1;
        dmem_rdata = 16'hBEEF;
        tick();
        checks++;
        if ({dmem_read, data_response} !== 2'b01) begin
            errors++;
            $display("FAIL ldw_resp: got %b expected 01",
                     {dmem_read, data_response});
        end
        checks++;
        if (mem_rdata_out !== 16'hBEEF) begin
            errors++;
            $display("FAIL ldw_data: got %h expected beef", mem_rdata_out);
        end
        dmem_resp = 1'b0;
        dmem_rdata = 16'h0;
        mem_read = 1'b0;
        ready = 1'b1;
        tick();
        tick();
        checks++;
        if (pulses !== 1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL ldw_pulse_once: got %0d/%b expected 1/0",
                     pulses, busy);
        end
    endtask

    task automatic test_byte;
        opcode = OP_LDB;
        addr_in = 16'h2001;
        mem_read = 1'b1;
        ready = 1'b0;
        tick();
        checks++;
        if (dmem_byte_enable !== 2'b10 || dmem_address !== 16'h2001) begin
            errors++;
            $display("FAIL ldb_be: got %b/%h expected 10/2001",
                     dmem_byte_enable, dmem_address);
        end
        dmem_resp = 1'b1;
        dmem_rdata = 16'h80FF;
        tick();
        checks++;
        if (mem_rdata_out !== 16'hFF80 || data_response !== 1'b1) begin
            errors++;
            $display("FAIL ldb_sext: got %h/%b expected ff80/1",
                     mem_rdata_out, data_response);
        end
        dmem_resp = 1'b0;
        mem_read = 1'b0;
        ready = 1'b1;
        tick();
        opcode = OP_STB;
        addr_in = 16'h2000;
        wdata_in = 16'h1234;
        mem_write = 1'b1;
        ready = 1'b0;
        tick();
        checks++;
        if ({dmem_read, dmem_write} !== 2'b01 || dmem_wdata !== 16'h3434) begin
            errors++;
            $display("FAIL stb_wdata: got %b/%h expected 01/3434",
                     {dmem_read, dmem_write}, dmem_wdata);
        end
        checks++;
        if (dmem_byte_enable !== 2'b01 || dmem_address !== 16'h2000) begin
            errors++;
            $display("FAIL stb_be: got %b/%h expected 01/2000",
                     dmem_byte_enable, dmem_address);
        end
        dmem_resp = 1'b1;
        tick();
        checks++;
        if (dmem_write !== 1'b0 || mem_rdata_out !== 16'hFF80) begin
            errors++;
            $display("FAIL stb_keep_rdata: got %b/%h expected 0/ff80",
                     dmem_write, mem_rdata_out);
        end
        dmem_resp = 1'b0;
        mem_write = 1'b0;
        ready = 1'b1;
        tick();
    endtask

    task automatic test_ldi;
        pulses = 0;
        opcode = OP_LDI;
        addr_in = 16'h4000;
        mem_read = 1'b1;
        ready = 1'b0;
        tick();
        checks++;
        if (dmem_read !== 1'b1 || dmem_address !== 16'h4000) begin
            errors++;
            $display("FAIL ldi_ptr_fetch: got %b/%h expected 1/4000",
                     dmem_read, dmem_address);
        end
        dmem_resp = 1'b1;
        dmem_rdata = 16'h5002;
        tick();
        checks++;
        if (data_response !== 1'b1 || mem_rdata_out !== 16'hFF80) begin
            errors++;
            $display("FAIL ldi_first_resp: got %b/%h expected 1/ff80",
                     data_response, mem_rdata_out);
        end
        dmem_resp = 1'b0;
        dmem_rdata = 16'h0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({dmem_read, dmem_write, busy} !== 3'b001) begin
                errors++;
                $display("FAIL ldi_wait2: got %b expected 001",
                         {dmem_read, dmem_write, busy});
            end
        end
        second_cycle_request = 1'b1;
        tick();
        checks++;
        if (dmem_read !== 1'b1 || dmem_address !== 16'h5002) begin
            errors++;
            $display("FAIL ldi_second: got %b/%h expected 1/5002",
                     dmem_read, dmem_address);
        end
        dmem_resp = 1'b1;
        dmem_rdata = 16'h00AA;
        tick();
        checks++;
        if (mem_rdata_out !== 16'h00AA) begin
            errors++;
            $display("FAIL ldi_data: got %h expected 00aa", mem_rdata_out);
        end
        dmem_resp = 1'b0;
        second_cycle_request = 1'b0;
        mem_read = 1'b0;
        ready = 1'b1;
        tick();
        checks++;
        if (pulses !== 2 || busy !== 1'b0) begin
            errors++;
            $display("FAIL ldi_pulses: got %0d/%b expected 2/0", pulses, busy);
        end
    endtask

    task automatic test_sti;
        pulses = 0;
        opcode = OP_STI;
        addr_in = 16'h4100;
        wdata_in = 16'h0F0F;
        mem_write = 1'b1;
        ready = 1'b0;
        tick();
        checks++;
        if ({dmem_read, dmem_write} !== 2'b10 || dmem_address !== 16'h4100) begin
            errors++;
            $display("FAIL sti_ptr_read: got %b/%h expected 10/4100",
                     {dmem_read, dmem_write}, dmem_address);
        end
        dmem_resp = 1'b1;
        dmem_rdata = 16'h6000;
        tick();
        dmem_resp = 1'b0;
        tick();
        second_cycle_request = 1'b1;
        tick();
        checks++;
        if ({dmem_read, dmem_write} !== 2'b01 || dmem_address !== 16'h6000) begin
            errors++;
            $display("FAIL sti_write: got %b/%h expected 01/6000",
                     {dmem_read, dmem_write}, dmem_address);
        end
        checks++;
        if (dmem_wdata !== 16'h0F0F || dmem_byte_enable !== 2'b11) begin
            errors++;
            $display("FAIL sti_wdata: got %h/%b expected 0f0f/11",
                     dmem_wdata, dmem_byte_enable);
        end
        dmem_resp = 1'b1;
        tick();
        checks++;
        if (mem_rdata_out !== 16'h00AA) begin
            errors++;
            $display("FAIL sti_keep_rdata: got %h expected 00aa", mem_rdata_out);
        end
        dmem_resp = 1'b0;
        second_cycle_request = 1'b0;
        mem_write = 1'b0;
        ready = 1'b1;
        tick();
        tick();
        checks++;
        if (pulses !== 2) begin
            errors++;
            $display("FAIL sti_pulses: got %0d expected 2", pulses);
        end
    endtask

    task automatic test_wait2_abort;
        opcode = OP_LDI;
        addr_in = 16'h4200;
        mem_read = 1'b1;
        ready = 1'b0;
        tick();
        dmem_resp = 1'b1;
        dmem_rdata = 16'h7000;
        tick();
        dmem_resp = 1'b0;
        mem_read = 1'b0;
        ready = 1'b1;
        tick();
        second_cycle_request = 1'b1;
        tick();
        checks++;
        if ({dmem_read, dmem_write, busy} !== 3'b000) begin
            errors++;
            $display("FAIL wait2_abort: got %b expected 000",
                     {dmem_read, dmem_write, busy});
        end
        second_cycle_request = 1'b0;
    endtask

    task automatic test_back_to_back;
        opcode = OP_LDW;
        addr_in = 16'h0010;
        mem_read = 1'b1;
        ready = 1'b0;
        tick();
        dmem_resp = 1'b1;
        dmem_rdata = 16'h1111;
        tick();
        dmem_resp = 1'b0;
        tick();
        tick();
        checks++;
        if ({dmem_read, busy} !== 2'b01) begin
            errors++;
            $display("FAIL b2b_no_retrigger: got %b expected 01",
                     {dmem_read, busy});
        end
        ready = 1'b1;
        tick();
        checks++;
        if (busy !== 1'b0 || mem_rdata_out !== 16'h1111) begin
            errors++;
            $display("FAIL b2b_idle: got %b/%h expected 0/1111",
                     busy, mem_rdata_out);
        end
        addr_in = 16'h0020;
        ready = 1'b0;
        tick();
        checks++;
        if (dmem_read !== 1'b1 || dmem_address !== 16'h0020) begin
            errors++;
            $display("FAIL b2b_restart: got %b/%h expected 1/0020",
                     dmem_read, dmem_address);
        end
        dmem_resp = 1'b1;
        dmem_rdata = 16'h2222;
        tick();
        dmem_resp = 1'b0;
        mem_read = 1'b0;
        ready = 1'b1;
        tick();
        checks++;
        if (mem_rdata_out !== 16'h2222 || busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_data: got %h/%b expected 2222/0",
                     mem_rdata_out, busy);
        end
    endtask

    task automatic test_reset_mid;
        opcode = OP_LDW;
        addr_in = 16'h1234;
        mem_read = 1'b1;
        ready = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        dmem_resp = 1'b1;
        dmem_rdata = 16'hFFFF;
        tick();
        checks++;
        if ({dmem_read, dmem_write, data_response, busy} !== 4'b0) begin
            errors++;
            $display("FAIL rstmid_ctrl: got %b expected 0000",
                     {dmem_read, dmem_write, data_response, busy});
        end
        checks++;
        if (stall_cycles !== 4'd0 || mem_rdata_out !== 16'h0) begin
            errors++;
            $display("FAIL rstmid_state: got %h/%h expected 0/0",
                     stall_cycles, mem_rdata_out);
        end
        reset = 1'b0;
        mem_read = 1'b0;
        ready = 1'b1;
        tick();
        checks++;
        if (data_response !== 1'b0 || mem_rdata_out !== 16'h0) begin
            errors++;
            $display("FAIL late_resp_ignored: got %b/%h expected 0/0",
                     data_response, mem_rdata_out);
        end
        dmem_resp = 1'b0;
        dmem_rdata = 16'h0;
    endtask

    task automatic test_nonmem;
        opcode = OP_ADD;
        ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({dmem_read, dmem_write, busy} !== 3'b000) begin
                errors++;
                $display("FAIL nonmem: got %b expected 000",
                         {dmem_read, dmem_write, busy});
            end
        end
        checks++;
        if (stall_cycles !== 4'd0) begin
            errors++;
            $display("FAIL nonmem_stall: got %0d expected 0", stall_cycles);
        end
        ready = 1'b1;
    endtask

    task automatic test_wrap;
        reset = 1'b1;
        idle_inputs();
        tick();
        reset = 1'b0;
        opcode = OP_LDW;
        addr_in = 16'h0100;
        mem_read = 1'b1;
        ready = 1'b0;
        tick();
        repeat (18) tick();
        checks++;
        if (stall_cycles !== 4'd2 || busy !== 1'b1) begin
            errors++;
            $display("FAIL stall_wrap: got %0d/%b expected 2/1",
                     stall_cycles, busy);
        end
        reset = 1'b1;
        idle_inputs();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_ldw();
        test_byte();
        test_ldi();
        test_sti();
        test_wait2_abort();
        test_back_to_back();
        test_reset_mid();
        test_nonmem();
        test_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
